true_dual_port_ram: RTL and testbench

//  Parametrised true dual-port synchronous RAM: ports A and B each read and write independently
//  on one clock. Adds byte enables, selectable same-port read mode, optional output register,

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_out_stage.sv | 26 ++
 rtl/true_dual_port_ram.sv | 112 +++++++++++
 tb/tb_true_dual_port_ram.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the true dual-port RAM.
//   RD_FIRST / WR_FIRST : encodings for the same-port read-during-write mode
//   be_merge_byte       : one byte of a byte-enable merge (new byte if enabled, else old)
package ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  function automatic logic [7:0] be_merge_byte(input logic [7:0] old_b,
                                               input logic [7:0] new_b,
                                               input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_out_stage.sv
// Optional per-port output register for the dual-port RAM.
//   clk, rst          : clock, async active-high reset
//   in_vld, in_data   : read result from the array stage
//   out_vld, out_data : registered result; data only moves when a valid result arrives
module ram_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) out_data <= in_data;
    end
  end

endmodule

// File: rtl/true_dual_port_ram.sv
// True dual-port synchronous RAM with byte enables, selectable same-port
// read-during-write behaviour, optional output register and a collision flag.
//   clk, rst                     : clock, async active-high reset (array not reset)
//   {a,b}_en/_we/_be/_addr/_wdata: per-port access request
//   {a,b}_rdata, {a,b}_rvalid    : per-port read result and its one-cycle strobe
//   collision                    : registered pulse, same address on both ports with a write
module true_dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int READ_MODE = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("true_dual_port_ram: DATA_W (%0d) must be a multiple of 8", DATA_W);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // A write with no byte enabled is treated as a pure read everywhere,
  // including the collision check.
  logic a_wr, b_wr;
  assign a_wr = a_en & a_we & (|a_be);
  assign b_wr = b_en & b_we & (|b_be);

  logic [DATA_W-1:0] a_old, b_old, a_merged, b_merged, a_rd_next, b_rd_next;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  always_comb begin
    a_merged = a_old;
    b_merged = b_old;
    for (int i = 0; i < NB; i++) begin
      a_merged[8*i +: 8] = be_merge_byte(a_old[8*i +: 8], a_wdata[8*i +: 8], a_wr & a_be[i]);
      b_merged[8*i +: 8] = be_merge_byte(b_old[8*i +: 8], b_wdata[8*i +: 8], b_wr & b_be[i]);
    end
  end

  // Write-first only sees its own port's write; the other port's write on
  // the same edge is never forwarded, so a cross-port reader gets old data.
  assign a_rd_next = (READ_MODE == WR_FIRST) ? a_merged : a_old;
  assign b_rd_next = (READ_MODE == WR_FIRST) ? b_merged : b_old;

  // Port A is written last so it wins bytes enabled on both ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++)
        if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      for (int i = 0; i < NB; i++)
        if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  logic [DATA_W-1:0] a_rd1, b_rd1;
  logic              a_vld1, b_vld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd1     <= '0;
      b_rd1     <= '0;
      a_vld1    <= 1'b0;
      b_vld1    <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_vld1    <= a_en;
      b_vld1    <= b_en;
      if (a_en) a_rd1 <= a_rd_next;
      if (b_en) b_rd1 <= b_rd_next;
      collision <= a_en & b_en & (a_addr == b_addr) & (a_wr | b_wr);
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    ram_out_stage #(.DATA_W(DATA_W)) u_out_a (
      .clk(clk), .rst(rst), .in_vld(a_vld1), .in_data(a_rd1),
      .out_vld(a_rvalid), .out_data(a_rdata)
    );
    ram_out_stage #(.DATA_W(DATA_W)) u_out_b (
      .clk(clk), .rst(rst), .in_vld(b_vld1), .in_data(b_rd1),
      .out_vld(b_rvalid), .out_data(b_rdata)
    );
  end else begin : g_noreg
    assign a_rdata  = a_rd1;
    assign a_rvalid = a_vld1;
    assign b_rdata  = b_rd1;
    assign b_rvalid = b_vld1;
  end

endmodule

// File: tb/tb_true_dual_port_ram.sv
module tb_true_dual_port_ram;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NB = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_en = 0, a_we = 0, b_en = 0, b_we = 0;
  logic [NB-1:0] a_be = '0, b_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  // channel 0/1: u0 ports A/B (read-first, latency 1); 2/3: u1 ports A/B (write-first, latency 2)
  logic [3:0][DW-1:0] rdp;
  logic [3:0]         rv;
  logic [1:0]         coll;

  true_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(rdp[0]), .a_rvalid(rv[0]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(rdp[1]), .b_rvalid(rv[1]),
    .collision(coll[0])
  );

  true_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(rdp[2]), .a_rvalid(rv[2]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(rdp[3]), .b_rvalid(rv[3]),
    .collision(coll[1])
  );

  typedef struct { int cyc; logic [DW-1:0] d; } exp_t;
  typedef struct { int cyc; logic v; } cexp_t;

  exp_t          eq [4][$];
  cexp_t         cq [$];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] last [4];
  string         chn [4] = '{"u0.a", "u0.b", "u1.a", "u1.b"};
  int            cyc = 0;
  int            n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected results whenever a port presents rvalid.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        chk({chn[i], " rvalid in reset"}, {31'd0, rv[i]}, '0);
        chk({chn[i], " rdata in reset"}, rdp[i], '0);
        last[i] = '0;
      end else if (rv[i]) begin
        if (eq[i].size() == 0) begin
          chk({chn[i], " unexpected rvalid"}, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = eq[i].pop_front();
          chk({chn[i], " latency cycle"}, cyc, e.cyc);
          chk({chn[i], " rdata"}, rdp[i], e.d);
          last[i] = e.d;
        end
      end else begin
        chk({chn[i], " rdata hold"}, rdp[i], last[i]);
        if (eq[i].size() != 0 && eq[i][0].cyc <= cyc) begin
          exp_t e;
          e = eq[i].pop_front();
          chk({chn[i], " missing rvalid"}, 32'd0, 32'd1);
        end
      end
    end
    while (cq.size() != 0 && cq[0].cyc < cyc) void'(cq.pop_front());
    if (rst) begin
      chk("collision in reset", {30'd0, coll}, '0);
      if (cq.size() != 0 && cq[0].cyc == cyc) void'(cq.pop_front());
    end else if (cq.size() != 0 && cq[0].cyc == cyc) begin
      cexp_t c;
      c = cq.pop_front();
      chk("u0 collision", {31'd0, coll[0]}, {31'd0, c.v});
      chk("u1 collision", {31'd0, coll[1]}, {31'd0, c.v});
    end
  end

  // Drive one cycle of requests and predict its results from the storage model.
  task automatic issue(input logic ae, input logic awe, input logic [NB-1:0] abe,
                       input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic ben, input logic bwe, input logic [NB-1:0] bbe,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    a_en = ae; a_we = awe; a_be = abe; a_addr = aad; a_wdata = awd;
    b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
    if (rst) begin
      cq.push_back('{cyc + 1, 1'b0});
    end else begin
      logic [DW-1:0] oa, ob, ma, mb;
      logic awr, bwr;
      oa = mem[aad]; ob = mem[bad]; ma = oa; mb = ob;
      awr = ae && awe && (abe != 0);
      bwr = ben && bwe && (bbe != 0);
      for (int i = 0; i < NB; i++) begin
        if (awr && abe[i]) ma[8*i +: 8] = awd[8*i +: 8];
        if (bwr && bbe[i]) mb[8*i +: 8] = bwd[8*i +: 8];
      end
      if (ae) begin
        eq[0].push_back('{cyc + 1, oa});
        eq[2].push_back('{cyc + 2, ma});
      end
      if (ben) begin
        eq[1].push_back('{cyc + 1, ob});
        eq[3].push_back('{cyc + 2, mb});
      end
      cq.push_back('{cyc + 1, ae && ben && (aad == bad) && (awr || bwr)});
      // A applied after B: A owns bytes both ports enable.
      for (int i = 0; i < NB; i++) if (bwr && bbe[i]) mem[bad][8*i +: 8] = bwd[8*i +: 8];
      for (int i = 0; i < NB; i++) if (awr && abe[i]) mem[aad][8*i +: 8] = awd[8*i +: 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_cycle();
    issue(($urandom % 4) != 0, $urandom % 2, NB'($urandom), AW'($urandom), $urandom,
          ($urandom % 4) != 0, $urandom % 2, NB'($urandom), AW'($urandom), $urandom);
  endtask

  // Reset in the middle of traffic: anything in flight is discarded and
  // writes presented while reset is high must not land.
  task automatic mid_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) eq[i].delete();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk({chn[i], " rvalid at reset assert"}, {31'd0, rv[i]}, '0);
      chk({chn[i], " rdata at reset assert"}, rdp[i], '0);
    end
    issue(1, 1, '1, 3'd0, 32'hDEAD_BEEF, 1, 1, '1, 3'd7, 32'hBAD0_BAD0);
    issue(1, 1, '1, 3'd1, 32'hDEAD_BEEF, 0, 0, '0, '0, '0);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk({chn[i], " reset rvalid"}, {31'd0, rv[i]}, '0);
    chk("reset collision", {30'd0, coll}, '0);
    rst = 1'b0;

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < DEPTH / 2; i++)
      issue(1, 1, '1, AW'(i), 32'h1000_0000 + i, 1, 1, '1, AW'(i + DEPTH / 2), 32'h2000_0000 + i);

    // byte-0 write then read back
    issue(1, 1, 4'b0001, 3'd3, 32'h0000_00A5, 0, 0, '0, '0, '0);
    issue(1, 0, '0, 3'd3, '0, 0, 0, '0, '0, '0);
    // partial byte enable merge
    issue(1, 1, 4'b1111, 3'd1, 32'h1122_3344, 0, 0, '0, '0, '0);
    issue(1, 1, 4'b0010, 3'd1, 32'hFFFF_FFFF, 0, 0, '0, '0, '0);
    issue(1, 0, '0, 3'd1, '0, 0, 0, '0, '0, '0);
    // cross-port write/read same address, then read the new data
    issue(1, 1, '1, 3'd2, 32'h0000_0000, 0, 0, '0, '0, '0);
    issue(1, 1, '1, 3'd2, 32'h0000_0055, 1, 0, '0, 3'd2, '0);
    issue(0, 0, '0, '0, '0, 1, 0, '0, 3'd2, '0);
    // both write same address: A wins on full overlap
    issue(1, 1, '1, 3'd5, 32'h0000_000F, 1, 1, '1, 3'd5, 32'h0000_00F0);
    issue(1, 0, '0, 3'd5, '0, 0, 0, '0, '0, '0);
    // partial overlap: bytes enabled on one port only take that port's data
    issue(1, 1, 4'b0011, 3'd6, 32'hAAAA_AAAA, 1, 1, 4'b0110, 3'd6, 32'hBBBB_BBBB);
    issue(0, 0, '0, '0, '0, 1, 0, '0, 3'd6, '0);
    // same-port read during write
    issue(1, 1, '1, 3'd4, 32'h0000_0033, 0, 0, '0, '0, '0);
    issue(1, 1, '1, 3'd4, 32'h0000_0077, 0, 0, '0, '0, '0);
    // we with be=0 is a pure read: no collision, no change
    issue(1, 1, '0, 3'd4, 32'hFFFF_FFFF, 1, 0, '0, 3'd4, '0);
    // reads-only on same address do not flag
    issue(1, 0, '0, 3'd7, '0, 1, 0, '0, 3'd7, '0);
    // address wrap at the top word
    issue(1, 1, '1, 3'd7, 32'hCAFE_F00D, 0, 0, '0, '0, '0);
    issue(0, 0, '0, '0, '0, 1, 0, '0, 3'd7, '0);
    idle();

    for (int i = 0; i < 300; i++) rand_cycle();

    // back-to-back reads, reset after the second
    for (int i = 0; i < 2; i++) issue(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(i + 2), '0);
    mid_reset();
    for (int i = 0; i < 4; i++) issue(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(i + 4), '0);

    for (int i = 0; i < 200; i++) rand_cycle();
    repeat (5) idle();

    for (int i = 0; i < 4; i++) chk({chn[i], " results left undelivered"}, eq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
